pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the memory-wait FSM states and the forward-select encodings.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // bit1 = forward, bit0 = source is MEM (1) or WB (0)
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_MEM     = 2'b11;

  localparam int CNT_W = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand bypass selection for one EX source register.
// A younger producer in MEM always wins over an older one in WB.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  mem_vld,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_vld,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hard-wired, so a write to it never produces a bypass.
  assign mem_hit = mem_vld & mem_we & (mem_rd != '0) & (mem_rd == src);
  assign wb_hit  = wb_vld & wb_we & (wb_rd != '0) & (wb_rd == src);

  always_comb begin
    sel = FWD_REGFILE;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage enables, flushes, valid tracking,
// load-use bubbles, branch redirects, data-memory wait states and forwarding.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DMEM_LAT     = 0,
  parameter int BRANCH_STAGE = 3
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_access,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  redirect,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            forward_rs,
  output logic [1:0]            forward_rt,
  output logic                  valid_id,
  output logic                  valid_ex,
  output logic                  valid_mem,
  output logic                  valid_wb,
  output logic                  load_use_stall,
  output logic                  mem_busy
);

  localparam bit               BR_AT_MEM = (BRANCH_STAGE == 3);
  localparam bit               HAS_WAIT  = (DMEM_LAT > 0);
  localparam bit               LAT_ONE   = (DMEM_LAT == 1);
  localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'((DMEM_LAT > 0) ? DMEM_LAT - 1 : 0);

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic             served, served_nxt;
  logic             vld_id_nxt, vld_ex_nxt, vld_mem_nxt, vld_wb_nxt;
  logic             redirect_hit, load_use, mem_start;
  logic             unused_ex_reg_write;

  // The EX write flag only matters once the instruction reaches MEM or WB.
  assign unused_ex_reg_write = ex_reg_write;

  assign redirect_hit = redirect & (BR_AT_MEM ? valid_mem : valid_ex);
  assign load_use     = valid_id & valid_ex & ex_mem_read & (ex_rd != '0) &
                        ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  assign mem_start    = HAS_WAIT & valid_mem & mem_access & ~served;
  assign cnt_dec      = cnt - CNT_W'(1);

  always_comb begin
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    load_use_stall = 1'b0;
    mem_busy       = 1'b0;
    state_nxt      = state;
    cnt_nxt        = cnt;
    served_nxt     = served;
    vld_id_nxt     = valid_id;
    vld_ex_nxt     = valid_ex;
    vld_mem_nxt    = valid_mem;
    vld_wb_nxt     = valid_wb;

    if (!srst) begin
      if (!enable) begin
        mem_busy = (state == MEM_WAIT);
      end else if (state == MEM_WAIT) begin
        // Redirects and load-use hazards wait here and are re-evaluated on release.
        mem_busy = 1'b1;
        cnt_nxt  = cnt_dec;
        if (cnt_dec == '0) begin
          state_nxt  = RUN;
          served_nxt = 1'b1;
        end
      end else if (mem_start) begin
        // The entry cycle is the first of the DMEM_LAT stall cycles.
        mem_busy = 1'b1;
        if (LAT_ONE) begin
          served_nxt = 1'b1;
        end else begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = LAT_M1;
        end
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        served_nxt  = 1'b0;
        vld_wb_nxt  = valid_mem;
        if (redirect_hit) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = BR_AT_MEM;
          vld_id_nxt  = 1'b0;
          vld_ex_nxt  = 1'b0;
          vld_mem_nxt = BR_AT_MEM ? 1'b0 : valid_ex;
        end else if (load_use) begin
          pc_en          = 1'b0;
          ifid_en        = 1'b0;
          idex_flush     = 1'b1;
          load_use_stall = 1'b1;
          vld_ex_nxt     = 1'b0;
          vld_mem_nxt    = valid_ex;
        end else begin
          vld_id_nxt  = 1'b1;
          vld_ex_nxt  = valid_id;
          vld_mem_nxt = valid_ex;
        end
      end
    end
  end

  // Stage boundary: control state and per-stage valid bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= RUN;
      cnt       <= '0;
      served    <= 1'b0;
      valid_id  <= 1'b0;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
      valid_wb  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      served    <= served_nxt;
      valid_id  <= vld_id_nxt;
      valid_ex  <= vld_ex_nxt;
      valid_mem <= vld_mem_nxt;
      valid_wb  <= vld_wb_nxt;
    end
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src     (ex_rs),
    .mem_vld (valid_mem),
    .mem_we  (mem_reg_write),
    .mem_rd  (mem_rd),
    .wb_vld  (valid_wb),
    .wb_we   (wb_reg_write),
    .wb_rd   (wb_rd),
    .sel     (forward_rs)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src     (ex_rt),
    .mem_vld (valid_mem),
    .mem_we  (mem_reg_write),
    .mem_rd  (mem_rd),
    .wb_vld  (valid_wb),
    .wb_we   (wb_reg_write),
    .wb_rd   (wb_rd),
    .sel     (forward_rt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cycle table followed by random
// traffic checked against a countdown-based behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int BR  = 3;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [1:0] F_RF    = 2'b00;
  localparam logic [1:0] F_WB    = 2'b10;
  localparam logic [1:0] F_MEM   = 2'b11;

  typedef struct {
    logic          srst, enable;
    logic [AW-1:0] id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_reg_write, ex_mem_read;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_write, mem_access;
    logic [AW-1:0] wb_rd;
    logic          wb_reg_write, redirect;
  } in_t;

  typedef struct {
    in_t         in;
    logic [17:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          srst, enable;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, mem_access, wb_reg_write, redirect;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic [1:0]    forward_rs, forward_rt;
  logic          valid_id, valid_ex, valid_mem, valid_wb, load_use_stall, mem_busy;
  logic [17:0]   dut_out;

  int n_vec = 0;
  int n_err = 0;

  vec_t  tbl[$];
  string names[$];

  // Behavioural model state: valid per stage, remaining wait cycles, served flag.
  logic [3:0] mv;
  int         m_wait;
  bit         m_served;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W   (AW),
    .DMEM_LAT     (LAT),
    .BRANCH_STAGE (BR)
  ) dut (
    .clk            (clk),
    .srst           (srst),
    .enable         (enable),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_access     (mem_access),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .redirect       (redirect),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .forward_rs     (forward_rs),
    .forward_rt     (forward_rt),
    .valid_id       (valid_id),
    .valid_ex       (valid_ex),
    .valid_mem      (valid_mem),
    .valid_wb       (valid_wb),
    .load_use_stall (load_use_stall),
    .mem_busy       (mem_busy)
  );

  assign dut_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush,
                    forward_rs, forward_rt,
                    valid_id, valid_ex, valid_mem, valid_wb,
                    load_use_stall, mem_busy};

  function automatic logic [17:0] mk(logic [4:0] en, logic [2:0] fl, logic [1:0] frs,
                                     logic [1:0] frt, logic [3:0] v, logic lus, logic busy);
    return {en, fl, frs, frt, v, lus, busy};
  endfunction

  function automatic in_t idle();
    in_t x;
    x.srst = 1'b0;          x.enable = 1'b1;
    x.id_rs = '0;           x.id_rt = '0;
    x.id_uses_rs = 1'b0;    x.id_uses_rt = 1'b0;
    x.ex_rs = '0;           x.ex_rt = '0;           x.ex_rd = '0;
    x.ex_reg_write = 1'b0;  x.ex_mem_read = 1'b0;
    x.mem_rd = '0;          x.mem_reg_write = 1'b0; x.mem_access = 1'b0;
    x.wb_rd = '0;           x.wb_reg_write = 1'b0;  x.redirect = 1'b0;
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.srst          = ($urandom_range(0, 39) == 0);
    x.enable        = ($urandom_range(0, 7) != 0);
    x.id_rs         = AW'($urandom_range(0, 3));
    x.id_rt         = AW'($urandom_range(0, 3));
    x.id_uses_rs    = 1'($urandom_range(0, 1));
    x.id_uses_rt    = 1'($urandom_range(0, 1));
    x.ex_rs         = AW'($urandom_range(0, 3));
    x.ex_rt         = AW'($urandom_range(0, 3));
    x.ex_rd         = AW'($urandom_range(0, 3));
    x.ex_reg_write  = 1'($urandom_range(0, 1));
    x.ex_mem_read   = 1'($urandom_range(0, 1));
    x.mem_rd        = AW'($urandom_range(0, 3));
    x.mem_reg_write = 1'($urandom_range(0, 1));
    x.mem_access    = ($urandom_range(0, 3) == 0);
    x.wb_rd         = AW'($urandom_range(0, 3));
    x.wb_reg_write  = 1'($urandom_range(0, 1));
    x.redirect      = ($urandom_range(0, 5) == 0);
    return x;
  endfunction

  task automatic drive(input in_t x);
    srst = x.srst;                   enable = x.enable;
    id_rs = x.id_rs;                 id_rt = x.id_rt;
    id_uses_rs = x.id_uses_rs;       id_uses_rt = x.id_uses_rt;
    ex_rs = x.ex_rs;                 ex_rt = x.ex_rt;           ex_rd = x.ex_rd;
    ex_reg_write = x.ex_reg_write;   ex_mem_read = x.ex_mem_read;
    mem_rd = x.mem_rd;               mem_reg_write = x.mem_reg_write;
    mem_access = x.mem_access;
    wb_rd = x.wb_rd;                 wb_reg_write = x.wb_reg_write;
    redirect = x.redirect;
  endtask

  task automatic add(input in_t x, input logic [17:0] e, input string nm);
    vec_t v;
    v.in  = x;
    v.exp = e;
    tbl.push_back(v);
    names.push_back(nm);
  endtask

  task automatic check(input string nm, input logic [17:0] e);
    n_vec++;
    if (dut_out !== e) begin
      n_err++;
      $display("FAIL %s: got %b required %b (en5 fl3 frs2 frt2 v4 lus busy)", nm, dut_out, e);
    end
  endtask

  function automatic logic [1:0] m_fwd(logic [AW-1:0] src, in_t x);
    if (mv[2] && x.mem_reg_write && x.mem_rd != '0 && x.mem_rd == src) return F_MEM;
    if (mv[3] && x.wb_reg_write && x.wb_rd != '0 && x.wb_rd == src) return F_WB;
    return F_RF;
  endfunction

  // One cycle of the reference: priority list evaluated top-down, waits as a countdown.
  task automatic model_step(input in_t x, output logic [17:0] e);
    logic [4:0] en;
    logic [2:0] fl;
    logic [3:0] nv;
    logic       lus, busy, redir, lu;
    en = EN_NONE; fl = FL_NONE; lus = 1'b0; busy = 1'b0; nv = mv;
    redir = x.redirect && ((BR == 3) ? mv[2] : mv[1]);
    lu = mv[0] && mv[1] && x.ex_mem_read && x.ex_rd != '0 &&
         ((x.id_uses_rs && x.id_rs == x.ex_rd) || (x.id_uses_rt && x.id_rt == x.ex_rd));
    if (x.srst) begin
      nv = 4'b0000; m_wait = 0; m_served = 1'b0;
    end else if (!x.enable) begin
      busy = (m_wait > 0);
    end else if (m_wait > 0) begin
      busy = 1'b1;
      m_wait--;
      if (m_wait == 0) m_served = 1'b1;
    end else if (LAT > 0 && mv[2] && x.mem_access && !m_served) begin
      busy = 1'b1;
      m_wait = LAT - 1;
      if (m_wait == 0) m_served = 1'b1;
    end else begin
      en = EN_ALL;
      m_served = 1'b0;
      nv[3] = mv[2];
      if (redir) begin
        fl = {1'b1, 1'b1, (BR == 3)};
        nv[0] = 1'b0; nv[1] = 1'b0; nv[2] = (BR == 3) ? 1'b0 : mv[1];
      end else if (lu) begin
        en = EN_LU; fl = 3'b010; lus = 1'b1;
        nv[1] = 1'b0; nv[2] = mv[1];
      end else begin
        nv[0] = 1'b1; nv[1] = mv[0]; nv[2] = mv[1];
      end
    end
    e = mk(en, fl, m_fwd(x.ex_rs, x), m_fwd(x.ex_rt, x), {mv[0], mv[1], mv[2], mv[3]}, lus, busy);
    mv = nv;
  endtask

  initial begin
    in_t         x;
    logic [17:0] e;

    x = idle(); x.srst = 1'b1;
    drive(x);
    repeat (2) @(posedge clk);

    // Reset and pipeline fill
    x = idle(); x.srst = 1'b1;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b0000, 1'b0, 1'b0), "reset");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b0000, 1'b0, 1'b0), "fill0");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1000, 1'b0, 1'b0), "fill1");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1100, 1'b0, 1'b0), "fill2");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1110, 1'b0, 1'b0), "fill3");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "full");
    // Load-use bubble
    x = idle(); x.ex_mem_read = 1'b1; x.ex_rd = 5; x.id_rs = 5; x.id_uses_rs = 1'b1;
    add(x,      mk(EN_LU,   3'b010,  F_RF, F_RF, 4'b1111, 1'b1, 1'b0), "load_use");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1011, 1'b0, 1'b0), "bubble_ex");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1101, 1'b0, 1'b0), "bubble_mem");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1110, 1'b0, 1'b0), "bubble_wb");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "refill");
    // Redirect beats load-use, then an unqualified redirect is ignored
    x.redirect = 1'b1;
    add(x,      mk(EN_ALL,  3'b111,  F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "redir_over_lu");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b0001, 1'b0, 1'b0), "redir_flushed");
    x = idle(); x.redirect = 1'b1;
    add(x,      mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1000, 1'b0, 1'b0), "redir_unqual");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1100, 1'b0, 1'b0), "refill1");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1110, 1'b0, 1'b0), "refill2");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "refill3");
    // Memory wait of 3 cycles, stretched by one disabled cycle
    x = idle(); x.mem_access = 1'b1;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mem_wait0");
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mem_wait1");
    x.enable = 1'b0;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mem_wait_hold");
    x.enable = 1'b1;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mem_wait2");
    add(x,      mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "mem_release");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "after_release");
    // Forwarding priority and register-0 exclusion
    x = idle(); x.mem_rd = 7; x.mem_reg_write = 1'b1; x.wb_rd = 7; x.wb_reg_write = 1'b1; x.ex_rs = 7;
    add(x,      mk(EN_ALL,  FL_NONE, F_MEM, F_RF, 4'b1111, 1'b0, 1'b0), "fwd_mem");
    x.mem_rd = 0;
    add(x,      mk(EN_ALL,  FL_NONE, F_WB,  F_RF, 4'b1111, 1'b0, 1'b0), "fwd_wb");
    x.mem_rd = 7; x.ex_rs = 0; x.ex_rt = 7;
    add(x,      mk(EN_ALL,  FL_NONE, F_RF,  F_MEM, 4'b1111, 1'b0, 1'b0), "fwd_rt_mem");
    x.mem_reg_write = 1'b0;
    add(x,      mk(EN_ALL,  FL_NONE, F_RF,  F_WB,  4'b1111, 1'b0, 1'b0), "fwd_rt_wb");
    // Reset in the middle of a memory wait
    x = idle(); x.mem_access = 1'b1;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mw_a");
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b1), "mw_b");
    x.srst = 1'b1;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1111, 1'b0, 1'b0), "srst_in_wait");
    x.srst = 1'b0;
    add(x,      mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b0000, 1'b0, 1'b0), "post_reset");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1000, 1'b0, 1'b0), "post_reset2");
    x = idle(); x.enable = 1'b0;
    add(x,      mk(EN_NONE, FL_NONE, F_RF, F_RF, 4'b1100, 1'b0, 1'b0), "disabled");
    add(idle(), mk(EN_ALL,  FL_NONE, F_RF, F_RF, 4'b1100, 1'b0, 1'b0), "disabled_hold");

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      check(names[i], tbl[i].exp);
    end

    // Random traffic, starting from a known reset
    @(negedge clk);
    x = idle(); x.srst = 1'b1;
    drive(x);
    mv = 4'b0000; m_wait = 0; m_served = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      x = rnd();
      drive(x);
      #1;
      model_step(x, e);
      check($sformatf("rand%0d", k), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
